axi_mem_slave: RTL
==================

# axi_mem_slave

AXI4 memory-mapped responder backed by an internal byte-writable RAM. It is the far end of the DMA controller's AXI master port: it accepts AR/AW bursts, returns read data and write responses, and stores written data for later read-back. Benches use it as the DMA target memory. It is also synthesizable as a small on-chip scratch RAM.

## Interface
- ADDR_WD, default 32: AXI address width; multiple of 8.
- DATA_WD, default 32: AXI data width; power-of-2 multiple of 8.
- MEM_WORDS, default 1024: RAM depth in DATA_WD words; power of 2.
- STRB_WD (localparam) = DATA_WD/8; OFS_WD (localparam) = log2(STRB_WD).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- S_AXI_ARVALID/ARREADY  in/out  1  read address handshake.
- S_AXI_ARADDR  in  ADDR_WD  read start byte address.
- S_AXI_ARLEN  in  8  beats minus one.
- S_AXI_ARSIZE  in  3  log2 bytes per beat.
- S_AXI_ARBURST  in  2  read burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- S_AXI_RVALID/RREADY  out/in  1  read data handshake.
- S_AXI_RDATA  out  DATA_WD  read data, full word.
- S_AXI_RRESP  out  2  read response: 0 OKAY, 2 SLVERR.
- S_AXI_RLAST  out  1  last read beat.
- S_AXI_AWVALID/AWREADY, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST: write address channel, same widths and meaning as the AR group.
- S_AXI_WVALID/WREADY  in/out  1  write data handshake.
- S_AXI_WDATA  in  DATA_WD  write data.
- S_AXI_WSTRB  in  STRB_WD  byte enables.
- S_AXI_WLAST  in  1  last write beat.
- S_AXI_BVALID/BREADY  out/in  1  write response handshake.
- S_AXI_BRESP  out  2  write response: 0 OKAY, 2 SLVERR.

## Operation
- Read and write paths are independent FSMs. Each path has one outstanding burst; no IDs and no reordering.
- RAM word index = addr[OFS_WD +: log2(MEM_WORDS)]. Upper address bits are ignored, so the RAM aliases across the address space. RAM contents are not reset.
- Burst error: the burst is errored if size > OFS_WD, burst == 3, or WRAP with len not in {1,3,7,15}.
- Address sequence, beat k+1 (byte address):
  - FIXED: unchanged.
  - INCR: (addr & ~(2^size-1)) + 2^size. Width ADDR_WD, wraps modulo 2^ADDR_WD.
  - WRAP: wrap window = (len+1)<<size, aligned to a multiple of the window. On reaching the window top, return to the window base.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AW handshake, latch addr/len/size/burst, clear the beat counter and error flag, go to W_DATA.
  - W_DATA: WREADY=1. Each W handshake writes bytes with WSTRB=1 to the current word, unless the burst is errored (then no write). The burst terminates on the handshake where beat counter == len.
  - WLAST mismatch: WLAST asserted on an earlier beat, or deasserted on the final beat, sets SLVERR. The counted length still governs termination.
  - W_RESP: BVALID=1, BRESP = SLVERR if errored else OKAY. Return to W_IDLE on B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. On AR handshake, latch the burst and load RDATA/RRESP/RLAST for beat 0 into registers.
  - R_DATA: RVALID=1. On each R handshake, load the next beat; on the handshake with RLAST=1, go to R_IDLE.
  - Errored read: every beat returns RDATA=0, RRESP=SLVERR. Beat count is still len+1.
  - RLAST=1 exactly on beat len.
- RDATA is always the full word. Narrow-transfer lane selection is the master's job.
- Same-cycle write beat and read fetch of the same word: the read returns pre-write data.

## Timing
- While rst=0, and on the first edge with rst=0: all READY/VALID outputs = 0; RDATA, RRESP, RLAST, BRESP = 0; both FSMs go to IDLE.
- First cycle after rst returns to 1: AWREADY=ARREADY=1.
- Reset mid-burst: the burst is abandoned with no R or B issued. RAM writes already done persist.
- Read latency: AR handshake at cycle N gives RVALID=1 with beat 0 at N+1. Back-to-back beats, 1 per cycle, when RREADY=1.
- Next ARREADY=1 the cycle after the RLAST handshake.
- Writes: WREADY=1 from the cycle after the AW handshake. BVALID=1 the cycle after the final W handshake. Next AWREADY=1 the cycle after the B handshake.
- VALID outputs and their payloads hold stable until handshake. READY outputs do not depend combinationally on VALID inputs.

## Test plan
- INCR write then read: AW addr 0x100, len 3, size 2, WDATA 0x11..0x44, WSTRB 0xF -> BRESP OKAY. AR to the same burst -> RDATA 0x11,0x22,0x33,0x44, RLAST on beat 3, RVALID at N+1.
- WRAP read: write words 0x40..0x4C = A,B,C,D. AR addr 0x48, len 3, WRAP, size 2 -> returns C,D,A,B.
- Byte strobes: word 0x200 holds 0xFFFFFFFF. Single write 0x12345678 with WSTRB 0b0101 -> readback 0xFF34FF78.
- Errors:
  - AW with burst 3 -> no RAM change, BRESP SLVERR.
  - AR with size 3 and len 1 (DATA_WD=32) -> 2 beats, RDATA 0, RRESP SLVERR, RLAST on beat 1.
  - Early WLAST on beat 0 of a len 1 burst -> both beats written, BRESP SLVERR.
- Backpressure: RREADY toggled 1,0,0,1 and BREADY held 0 for 5 cycles -> outputs stable, no beat lost or duplicated.
- Reset mid-burst: drop rst after 2 of 4 read beats -> RVALID=0 next cycle. ARREADY=1 the first cycle after reset release; new read returns correct data.

Source files
------------

// File: rtl/axi_mem_slave.sv
// AXI4 memory-mapped responder backed by a byte-writable RAM.
// Independent read and write FSMs, one outstanding burst per direction.
module axi_mem_slave #(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_ARADDR,
  input  logic [7:0]           S_AXI_ARLEN,
  input  logic [2:0]           S_AXI_ARSIZE,
  input  logic [1:0]           S_AXI_ARBURST,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [DATA_WD-1:0]   S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RLAST,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [ADDR_WD-1:0]   S_AXI_AWADDR,
  input  logic [7:0]           S_AXI_AWLEN,
  input  logic [2:0]           S_AXI_AWSIZE,
  input  logic [1:0]           S_AXI_AWBURST,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  input  logic [DATA_WD-1:0]   S_AXI_WDATA,
  input  logic [DATA_WD/8-1:0] S_AXI_WSTRB,
  input  logic                 S_AXI_WLAST,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  output logic [1:0]           S_AXI_BRESP
);
  localparam int STRB_WD = DATA_WD / 8;
  localparam int OFS_WD  = $clog2(STRB_WD);
  localparam int IDX_WD  = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    return (size > 3'(OFS_WD)) || (burst == 2'd3) ||
           ((burst == 2'd2) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
  endfunction

  function automatic logic [ADDR_WD-1:0] next_addr(input logic [ADDR_WD-1:0] addr,
                                                   input logic [7:0] len, input logic [2:0] size,
                                                   input logic [1:0] burst);
    logic [ADDR_WD-1:0] bytes, incr, window, base;
    bytes  = ADDR_WD'(1) << size;
    incr   = (addr & ~(bytes - 1'b1)) + bytes;
    window = (ADDR_WD'(len) + ADDR_WD'(1)) << size;
    base   = addr & ~(window - 1'b1);
    case (burst)
      2'd0:    return addr;
      // Wrap: keep the window base, let the offset roll over inside the window.
      2'd2:    return base | (incr & (window - 1'b1));
      default: return incr;
    endcase
  endfunction

  function automatic logic [IDX_WD-1:0] word_idx(input logic [ADDR_WD-1:0] a);
    return a[OFS_WD +: IDX_WD];
  endfunction

  logic [DATA_WD-1:0] mem [MEM_WORDS];

  // Write path state
  w_state_t           w_state;
  logic [ADDR_WD-1:0] w_addr;
  logic [7:0]         w_len, w_cnt;
  logic [2:0]         w_size;
  logic [1:0]         w_burst;
  logic               w_bad, w_last_err;
  logic               w_fire, w_final, w_last_bad;

  always_comb begin
    w_fire     = (w_state == W_DATA) && S_AXI_WVALID && S_AXI_WREADY;
    w_final    = (w_cnt == w_len);
    w_last_bad = (S_AXI_WLAST != w_final);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= 2'b00;
      w_cnt         <= '0;
      w_bad         <= 1'b0;
      w_last_err    <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          S_AXI_AWREADY <= 1'b1;
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            w_addr        <= S_AXI_AWADDR;
            w_len         <= S_AXI_AWLEN;
            w_size        <= S_AXI_AWSIZE;
            w_burst       <= S_AXI_AWBURST;
            w_cnt         <= '0;
            w_bad         <= burst_bad(S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST);
            w_last_err    <= 1'b0;
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_last_bad) w_last_err <= 1'b1;
            // The counted length, not WLAST, ends the burst.
            if (w_final) begin
              S_AXI_WREADY <= 1'b0;
              S_AXI_BVALID <= 1'b1;
              S_AXI_BRESP  <= (w_bad || w_last_err || w_last_bad) ? 2'b10 : 2'b00;
              w_state      <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
            S_AXI_AWREADY <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the RAM array is deliberately left out of reset so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (rst && w_fire && !w_bad) begin
      for (int b = 0; b < STRB_WD; b++) begin
        if (S_AXI_WSTRB[b]) mem[word_idx(w_addr)][b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
      end
    end
  end

  // Read path state
  r_state_t           r_state;
  logic [ADDR_WD-1:0] r_addr, r_next;
  logic [7:0]         r_len, r_cnt;
  logic [2:0]         r_size;
  logic [1:0]         r_burst;
  logic               r_bad, ar_bad;

  always_comb begin
    r_next = next_addr(r_addr, r_len, r_size, r_burst);
    ar_bad = burst_bad(S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST);
  end

  // NOTE: non-blocking RAM reads here see the array before any same-edge write lands,
  // which is exactly the read-before-write behaviour the master expects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= 2'b00;
      S_AXI_RLAST   <= 1'b0;
      r_cnt         <= '0;
      r_bad         <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          S_AXI_ARREADY <= 1'b1;
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            r_addr        <= S_AXI_ARADDR;
            r_len         <= S_AXI_ARLEN;
            r_size        <= S_AXI_ARSIZE;
            r_burst       <= S_AXI_ARBURST;
            r_cnt         <= '0;
            r_bad         <= ar_bad;
            S_AXI_RDATA   <= ar_bad ? '0 : mem[word_idx(S_AXI_ARADDR)];
            S_AXI_RRESP   <= ar_bad ? 2'b10 : 2'b00;
            S_AXI_RLAST   <= (S_AXI_ARLEN == 8'd0);
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            if (S_AXI_RLAST) begin
              S_AXI_RVALID  <= 1'b0;
              S_AXI_RLAST   <= 1'b0;
              S_AXI_RDATA   <= '0;
              S_AXI_RRESP   <= 2'b00;
              S_AXI_ARREADY <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              S_AXI_RDATA <= r_bad ? '0 : mem[word_idx(r_next)];
              S_AXI_RLAST <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule
